// File: rtl/ghost_pkg.sv
// ghost_pkg -- shared definitions for the ghost movement controller.
//   dir_t        one-hot heading {L,U,R,D} (bit 3 = L ... bit 0 = D)
//   DIR_*        one-hot heading constants
//   mode_t       2-bit behaviour mode, MODE_* encodings
//   reverse_dir  returns the opposite heading of a one-hot dir_t
package ghost_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_L = 4'b1000;
    localparam dir_t DIR_U = 4'b0100;
    localparam dir_t DIR_R = 4'b0010;
    localparam dir_t DIR_D = 4'b0001;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_CHASE   = 2'd0;
    localparam mode_t MODE_SCATTER = 2'd1;
    localparam mode_t MODE_FRIGHT  = 2'd2;

    // L<->R and U<->D are two bit positions apart, so reversal is a
    // rotate by two.
    function automatic dir_t reverse_dir(input dir_t d);
        return {d[1], d[0], d[3], d[2]};
    endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// ghost_dir_select -- combinational turn chooser used when the current
// heading is blocked by a wall.
// Ports:
//   dir        in  4  current heading, one-hot {L,U,R,D}
//   wall_free  in  4  {L,U,R,D} legal-step flags at the ghost position
//   dx_neg     in  1  target is left of the ghost (dx < 0)
//   dy_neg     in  1  target is above the ghost (dy < 0)
//   flee       in  1  invert the target preference (run away)
//   next_dir   out 4  heading to adopt; equals dir when no exit exists
module ghost_dir_select
    import ghost_pkg::*;
(
    input  logic [3:0] dir,
    input  logic [3:0] wall_free,
    input  logic       dx_neg,
    input  logic       dy_neg,
    input  logic       flee,
    output logic [3:0] next_dir
);

    dir_t pref_v;
    dir_t pref_h;
    dir_t first_try;
    dir_t second_try;
    dir_t back;
    logic moving_h;

    // dy >= 0 means the target is below (screen y grows downward).
    assign pref_v     = (dy_neg ^ flee) ? DIR_U : DIR_D;
    assign pref_h     = (dx_neg ^ flee) ? DIR_L : DIR_R;
    assign moving_h   = |(dir & (DIR_L | DIR_R));

    // A blocked horizontal mover turns onto the vertical axis first and
    // vice versa; reversing is the last resort.
    assign first_try  = moving_h ? pref_v : pref_h;
    assign second_try = reverse_dir(first_try);
    assign back       = reverse_dir(dir);

    always_comb begin
        // NOTE: next_dir gets a value on every path (default first), so no latch is inferred.
        next_dir = dir;
        if (|(wall_free & first_try)) begin
            next_dir = first_try;
        end else if (|(wall_free & second_try)) begin
            next_dir = second_try;
        end else if (|(wall_free & back)) begin
            next_dir = back;
        end
    end

endmodule

// File: rtl/ghost_chaser.sv
// ghost_chaser -- one ghost's movement controller, stepped by move_tick.
// Walks the maze, turns toward its target only at walls, alternates
// CHASE/SCATTER on a move_tick-counted timer and flags overlap with the
// player.
// Optional feature: define GHOST_FRIGHT_EN to build the frightened mode
// (fright_start input becomes live, mode can become 2).
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous reset, active-high
//   move_tick     in   1   one-cycle step strobe
//   p_x, p_y      in   CW  player position
//   wall_free     in   4   {L,U,R,D} legal-step flags at (m_x,m_y)
//   fright_start  in   1   start frightened period (GHOST_FRIGHT_EN only)
//   m_x, m_y      out  CW  ghost position
//   dir           out  4   heading, one-hot {L,U,R,D}
//   mode          out  2   0 CHASE, 1 SCATTER, 2 FRIGHT
//   hit           out  1   registered overlap with player
module ghost_chaser
    import ghost_pkg::*;
#(
    parameter int         CW            = 9,
    parameter int         VEL           = 1,
    parameter int         START_X       = 100,
    parameter int         START_Y       = 30,
    parameter logic [3:0] START_DIR     = 4'b0010,
    parameter int         CORNER_X      = 0,
    parameter int         CORNER_Y      = 0,
    parameter int         CHASE_TICKS   = 400,
    parameter int         SCATTER_TICKS = 100,
    parameter int         HIT_DIST      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move_tick,
    input  logic [CW-1:0] p_x,
    input  logic [CW-1:0] p_y,
    input  logic [3:0]    wall_free,
    input  logic          fright_start,
    output logic [CW-1:0] m_x,
    output logic [CW-1:0] m_y,
    output logic [3:0]    dir,
    output logic [1:0]    mode,
    output logic          hit
);

    localparam int MAX_TICKS = (CHASE_TICKS > SCATTER_TICKS) ? CHASE_TICKS : SCATTER_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0]      CHASE_LAST   = TW'(CHASE_TICKS - 1);
    localparam logic [TW-1:0]      SCATTER_LAST = TW'(SCATTER_TICKS - 1);
    localparam logic [CW-1:0]      VEL_C        = CW'(VEL);
    localparam logic [CW-1:0]      X0           = CW'(START_X);
    localparam logic [CW-1:0]      Y0           = CW'(START_Y);
    localparam logic [CW-1:0]      CORNER_XC    = CW'(CORNER_X);
    localparam logic [CW-1:0]      CORNER_YC    = CW'(CORNER_Y);
    localparam logic signed [CW:0] HIT_LIM      = (CW+1)'(HIT_DIST);
    localparam logic signed [CW:0] ZERO         = '0;

    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_nx;
    logic [CW-1:0]      x_nx;
    logic [CW-1:0]      y_nx;
    logic [CW-1:0]      tx;
    logic [CW-1:0]      ty;
    dir_t               dir_nx;
    dir_t               turn_dir;
    mode_t              mode_nx;
    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic signed [CW:0] hx;
    logic signed [CW:0] hy;
    logic               blocked;
    logic               flee;
    logic               normal_tick;
    logic               mode_switch;
    logic               do_move;
    logic               hit_nx;

    // FRIGHT keeps the player as target; flee inverts the preference.
    assign tx = (mode == MODE_SCATTER) ? CORNER_XC : p_x;
    assign ty = (mode == MODE_SCATTER) ? CORNER_YC : p_y;

    // Zero-extended, (CW+1)-bit signed differences: no wrap ambiguity.
    assign dx = $signed({1'b0, tx})  - $signed({1'b0, m_x});
    assign dy = $signed({1'b0, ty})  - $signed({1'b0, m_y});
    assign hx = $signed({1'b0, p_x}) - $signed({1'b0, m_x});
    assign hy = $signed({1'b0, p_y}) - $signed({1'b0, m_y});

    assign hit_nx  = (hx < HIT_LIM) && (hx > -HIT_LIM) && (hy < HIT_LIM) && (hy > -HIT_LIM);
    assign blocked = (wall_free & dir) == 4'b0000;

    assign mode_switch = ((mode == MODE_CHASE)   && (timer == CHASE_LAST)) ||
                         ((mode == MODE_SCATTER) && (timer == SCATTER_LAST));

    ghost_dir_select u_dir_select (
        .dir       (dir),
        .wall_free (wall_free),
        .dx_neg    (dx < ZERO),
        .dy_neg    (dy < ZERO),
        .flee      (flee),
        .next_dir  (turn_dir)
    );

`ifdef GHOST_FRIGHT_EN
    localparam int            FW          = $clog2(2 * SCATTER_TICKS + 1);
    localparam logic [FW-1:0] FRIGHT_LOAD = FW'(2 * SCATTER_TICKS);

    logic [FW-1:0] fright_cnt;
    logic [FW-1:0] cnt_nx;
    logic          fright_phase;
    logic          phase_nx;
    mode_t         saved_mode;
    mode_t         saved_nx;

    assign flee        = (mode == MODE_FRIGHT);
    // The CHASE/SCATTER timer only advances outside FRIGHT, which freezes it.
    assign normal_tick = move_tick && !fright_start && !flee;
`else
    logic unused_fright;

    assign flee          = 1'b0;
    assign normal_tick   = move_tick;
    assign unused_fright = fright_start;
`endif

    always_comb begin
        x_nx     = m_x;
        y_nx     = m_y;
        dir_nx   = dir;
        mode_nx  = mode;
        timer_nx = timer;
        do_move  = 1'b0;

        // A mode switch spends its tick on the reversal, even when the
        // current heading is also blocked.
        if (normal_tick) begin
            if (mode_switch) begin
                mode_nx  = (mode == MODE_CHASE) ? MODE_SCATTER : MODE_CHASE;
                timer_nx = '0;
                dir_nx   = reverse_dir(dir);
            end else begin
                timer_nx = timer + 1'b1;
                do_move  = 1'b1;
            end
        end

`ifdef GHOST_FRIGHT_EN
        cnt_nx   = fright_cnt;
        phase_nx = fright_phase;
        saved_nx = saved_mode;
        if (fright_start) begin
            cnt_nx   = FRIGHT_LOAD;
            phase_nx = 1'b0;
            // A restart while already frightened only reloads the counter.
            if (!flee) begin
                saved_nx = mode;
                mode_nx  = MODE_FRIGHT;
                dir_nx   = reverse_dir(dir);
            end
        end else if (move_tick && flee) begin
            // Half speed: act on every second tick only.
            phase_nx = ~fright_phase;
            do_move  = fright_phase;
            if (fright_cnt == FW'(1)) begin
                mode_nx = saved_mode;
            end else begin
                cnt_nx = fright_cnt - 1'b1;
            end
        end
`endif

        // Position and heading never change together: either step or turn.
        if (do_move) begin
            if (blocked) begin
                dir_nx = turn_dir;
            end else begin
                case (dir)
                    DIR_L:   x_nx = m_x - VEL_C;
                    DIR_R:   x_nx = m_x + VEL_C;
                    DIR_U:   y_nx = m_y - VEL_C;
                    DIR_D:   y_nx = m_y + VEL_C;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            m_x   <= X0;
            m_y   <= Y0;
            dir   <= START_DIR;
            mode  <= MODE_CHASE;
            timer <= '0;
            hit   <= 1'b0;
        end else begin
            m_x   <= x_nx;
            m_y   <= y_nx;
            dir   <= dir_nx;
            mode  <= mode_nx;
            timer <= timer_nx;
            hit   <= hit_nx;
        end
    end

`ifdef GHOST_FRIGHT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fright_cnt   <= '0;
            fright_phase <= 1'b0;
            saved_mode   <= MODE_CHASE;
        end else begin
            fright_cnt   <= cnt_nx;
            fright_phase <= phase_nx;
            saved_mode   <= saved_nx;
        end
    end
`endif

endmodule
